// File: rtl/wb_fb_rect_fill_if.sv
// Wishbone classic write-bus bundle between the rectangle filler (master)
// and the framebuffer slave port.
interface wb_fb_rect_fill_if;
    logic [14:0] O_wb_adr;
    logic [7:0]  O_wb_dat;
    logic        O_wb_we;
    logic        O_wb_stb;
    logic        O_wb_cyc;
    logic        I_wb_ack;

    modport master (
        output O_wb_adr, O_wb_dat, O_wb_we, O_wb_stb, O_wb_cyc,
        input  I_wb_ack
    );

    modport slave (
        input  O_wb_adr, O_wb_dat, O_wb_we, O_wb_stb, O_wb_cyc,
        output I_wb_ack
    );
endinterface

// File: rtl/wb_fb_rect_fill.sv
// Rectangle fill engine: writes one colour byte per pixel of a clipped,
// axis-aligned rectangle into the RGB332 framebuffer over Wishbone classic.
// Row-major scan; cyc is held for the whole rectangle and stb is dropped for
// one GAP cycle between pixels so the slave's registered ack can clear.
module wb_fb_rect_fill #(
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  I_wb_clk,
    input  logic                  I_wb_rst,
    input  logic                  I_start,
    input  logic [7:0]            I_x,
    input  logic [6:0]            I_y,
    input  logic [7:0]            I_w,
    input  logic [6:0]            I_h,
    input  logic [7:0]            I_color,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_err,
    wb_fb_rect_fill_if.master     wb
);

    localparam logic [14:0] FB_W15  = 15'(FB_WIDTH);
    localparam logic [8:0]  FB_W9   = 9'(FB_WIDTH);
    localparam logic [7:0]  FB_H8   = 8'(FB_HEIGHT);
    localparam logic [7:0]  TO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [7:0]  w_q, w_d;
    logic [6:0]  h_q, h_d;
    logic [7:0]  color_q, color_d;
    logic [7:0]  ew_q, ew_d;
    logic [6:0]  eh_q, eh_d;
    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic [14:0] row_base_q, row_base_d;
    logic [7:0]  wait_q, wait_d;
    logic [14:0] adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [8:0]  avail_x_s;
    logic [7:0]  avail_y_s;
    logic [7:0]  ew_s;
    logic [6:0]  eh_s;
    logic        empty_s;
    logic [14:0] base_s;
    logic        col_last_s;
    logic        row_last_s;

    // Clipping, emptiness test and y*FB_WIDTH as an unrolled shift-add.
    always_comb begin
        avail_x_s = FB_W9 - {1'b0, x_q};
        avail_y_s = FB_H8 - {1'b0, y_q};
        ew_s      = ({1'b0, w_q} < avail_x_s) ? w_q : avail_x_s[7:0];
        eh_s      = ({1'b0, h_q} < avail_y_s) ? h_q : avail_y_s[6:0];
        empty_s   = ({1'b0, x_q} >= FB_W9) || ({1'b0, y_q} >= FB_H8) ||
                    (w_q == 8'd0) || (h_q == 7'd0);
        base_s    = 15'd0;
        for (int b = 0; b < 15; b++) begin
            if (FB_W15[b]) begin
                base_s = base_s + ({8'd0, y_q} << b);
            end else begin
                base_s = base_s;
            end
        end
        col_last_s = (col_q == (ew_q - 8'd1));
        row_last_s = (row_q == (eh_q - 7'd1));
    end

    // Next-state and registered-output computation for the fill FSM.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        ew_d       = ew_q;
        eh_d       = eh_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        wait_d     = wait_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                cyc_d  = 1'b0;
                stb_d  = 1'b0;
                we_d   = 1'b0;
                busy_d = 1'b0;
                if (I_start) begin
                    x_d     = I_x;
                    y_d     = I_y;
                    w_d     = I_w;
                    h_d     = I_h;
                    color_d = I_color;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (empty_s) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ew_d       = ew_s;
                    eh_d       = eh_s;
                    row_base_d = base_s;
                    col_d      = 8'd0;
                    row_d      = 7'd0;
                    wait_d     = 8'd0;
                    adr_d      = base_s + {7'd0, x_q};
                    dat_d      = color_q;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    we_d       = 1'b1;
                    state_d    = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (wb.I_wb_ack) begin
                    if (col_last_s && row_last_s) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        if (col_last_s) begin
                            col_d      = 8'd0;
                            row_d      = row_q + 7'd1;
                            row_base_d = row_base_q + FB_W15;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                        stb_d   = 1'b0;
                        state_d = ST_GAP;
                    end
                end else if (wait_q == TO_LAST) begin
                    // Slave never answered: abandon the whole command.
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            ST_GAP: begin
                // Counters were advanced on the ack; present the next pixel.
                adr_d   = row_base_q + {7'd0, x_q} + {7'd0, col_q};
                wait_d  = 8'd0;
                stb_d   = 1'b1;
                state_d = ST_WRITE;
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
        if (I_wb_rst) begin
            state_q    <= ST_IDLE;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            w_q        <= 8'd0;
            h_q        <= 7'd0;
            color_q    <= 8'd0;
            ew_q       <= 8'd0;
            eh_q       <= 7'd0;
            col_q      <= 8'd0;
            row_q      <= 7'd0;
            row_base_q <= 15'd0;
            wait_q     <= 8'd0;
            adr_q      <= 15'd0;
            dat_q      <= 8'd0;
            we_q       <= 1'b0;
            stb_q      <= 1'b0;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            ew_q       <= ew_d;
            eh_q       <= eh_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            wait_q     <= wait_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            stb_q      <= stb_d;
            cyc_q      <= cyc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wb.O_wb_adr = adr_q;
    assign wb.O_wb_dat = dat_q;
    assign wb.O_wb_we  = we_q;
    assign wb.O_wb_stb = stb_q;
    assign wb.O_wb_cyc = cyc_q;
    assign O_busy      = busy_q;
    assign O_done      = done_q;
    assign O_err       = err_q;

endmodule
